board_move_sequencer: RTL and testbench

Owns the 64-square chess board state and sequences every change to it. It loads the starting position after reset and accepts move requests over a valid/ready handshake. Each accepted move is applied as a clear-source then write-destination pair on a single write port. It also holds the available-square mask with its flash phase and serves registered per-square lookups to the OLED board renderer.

---
 rtl/chess_pkg.sv | 55 +++++
 rtl/board_ram.sv | 26 ++
 rtl/board_move_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_board_move_sequencer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared chess encodings for the board sequencer: piece codes, colours, reject reasons,
// sequencer states and the start-position table used while the board loads.
package chess_pkg;

   typedef enum logic [2:0] {
      PcEmpty  = 3'd0,
      PcPawn   = 3'd1,
      PcBishop = 3'd2,
      PcKnight = 3'd3,
      PcRook   = 3'd4,
      PcQueen  = 3'd5,
      PcKing   = 3'd6
   } piece_e;

   localparam logic ColWhite = 1'b0;
   localparam logic ColBlack = 1'b1;

   typedef enum logic [1:0] {
      ErrNone  = 2'd0,
      ErrEmpty = 2'd1,
      ErrTurn  = 2'd2,
      ErrOwn   = 2'd3
   } err_e;

   typedef enum logic [2:0] {
      StInit,
      StIdle,
      StFetch,
      StCheck,
      StClr,
      StSet
   } state_e;

   // Square is row*8+col; rows 0-1 are black, rows 6-7 white, empty squares carry colour 0.
   function automatic logic [3:0] start_piece(input logic [5:0] sq);
      piece_e code;
      logic   colour;
      case (sq[5:3])
         3'd0, 3'd7: begin
            case (sq[2:0])
               3'd0, 3'd7: code = PcRook;
               3'd1, 3'd6: code = PcKnight;
               3'd2, 3'd5: code = PcBishop;
               3'd3:       code = PcQueen;
               default:    code = PcKing;
            endcase
         end
         3'd1, 3'd6: code = PcPawn;
         default:    code = PcEmpty;
      endcase
      colour = (sq[5:3] <= 3'd1) ? ColBlack : ColWhite;
      return {colour, code};
   endfunction

endpackage

// File: rtl/board_ram.sv
// 64x4 board storage: one synchronous write port, combinational reads for the renderer
// and for the source/destination squares of the move in flight.
module board_ram (
   input  logic       clock,
   input  logic       we,
   input  logic [5:0] waddr,
   input  logic [3:0] wdata,
   input  logic [5:0] rd_addr,
   input  logic [5:0] from_addr,
   input  logic [5:0] to_addr,
   output logic [3:0] rd_data,
   output logic [3:0] from_data,
   output logic [3:0] to_data
);

   logic [3:0] mem [64];

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rd_data   = mem[rd_addr];
   assign from_data = mem[from_addr];
   assign to_data   = mem[to_addr];

endmodule

// File: rtl/board_move_sequencer.sv
// Owns the chess board: loads the start position, applies moves as clear/set write pairs,
// holds the available-square mask with its flash phase and serves renderer lookups.
module board_move_sequencer
   import chess_pkg::*;
#(
   parameter int unsigned FLASH_DIV = 25_000_000
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        mv_valid,
   output logic        mv_ready,
   input  logic [5:0]  mv_from,
   input  logic [5:0]  mv_to,
   input  logic        avail_valid,
   input  logic [63:0] avail_mask,
   input  logic [5:0]  rd_sq,
   output logic [3:0]  rd_piece,
   output logic        rd_avail,
   output logic        flash,
   output logic        turn,
   output logic        done_pulse,
   output logic        err_pulse,
   output logic [1:0]  err_code
);

   localparam int unsigned CntW = $clog2(FLASH_DIV);

   state_e      state_q, state_d;
   logic [5:0]  idx_q, idx_d;
   logic [5:0]  from_q, from_d, to_q, to_d;
   logic [3:0]  src_q, src_d, dst_q, dst_d;
   logic        turn_q, turn_d;
   logic [63:0] mask_q, mask_d;
   logic        done_q, done_d, err_q, err_d;
   logic [1:0]  err_code_q, err_code_d;
   logic [CntW-1:0] flash_cnt_q;
   logic        flash_q;
   logic [3:0]  rd_piece_q;
   logic        rd_avail_q;

   logic        we;
   logic [5:0]  waddr;
   logic [3:0]  wdata;
   logic [3:0]  rd_data, from_data, to_data;
   logic        promote;
   logic [3:0]  set_data;

   board_ram u_board_ram (
      .clock     (clock),
      .we        (we & rst_n),
      .waddr     (waddr),
      .wdata     (wdata),
      .rd_addr   (rd_sq),
      .from_addr (from_q),
      .to_addr   (to_q),
      .rd_data   (rd_data),
      .from_data (from_data),
      .to_data   (to_data)
   );

   // A pawn reaching the far rank for its colour is stored as a queen.
   assign promote  = (src_q[2:0] == PcPawn) &&
                     ((src_q[3] == ColWhite && to_q[5:3] == 3'd0) ||
                      (src_q[3] == ColBlack && to_q[5:3] == 3'd7));
   assign set_data = promote ? {src_q[3], PcQueen} : src_q;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      from_d     = from_q;
      to_d       = to_q;
      src_d      = src_q;
      dst_d      = dst_q;
      turn_d     = turn_q;
      mask_d     = avail_valid ? avail_mask : mask_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = err_code_q;
      we         = 1'b0;
      waddr      = idx_q;
      wdata      = start_piece(idx_q);
      unique case (state_q)
         StInit: begin
            we     = 1'b1;
            idx_d  = idx_q + 6'd1;
            mask_d = '0;
            turn_d = ColWhite;
            if (idx_q == 6'd63) state_d = StIdle;
         end
         StIdle: begin
            if (mv_valid) begin
               from_d  = mv_from;
               to_d    = mv_to;
               state_d = StFetch;
            end
         end
         StFetch: begin
            src_d   = from_data;
            dst_d   = to_data;
            state_d = StCheck;
         end
         StCheck: begin
            state_d = StIdle;
            err_d   = 1'b1;
            if (src_q[2:0] == PcEmpty) begin
               err_code_d = ErrEmpty;
            end else if (src_q[3] != turn_q) begin
               err_code_d = ErrTurn;
            end else if ((from_q == to_q) ||
                         (dst_q[2:0] != PcEmpty && dst_q[3] == src_q[3])) begin
               err_code_d = ErrOwn;
            end else begin
               err_d   = 1'b0;
               state_d = StClr;
            end
         end
         StClr: begin
            we      = 1'b1;
            waddr   = from_q;
            wdata   = 4'b0000;
            state_d = StSet;
         end
         StSet: begin
            we      = 1'b1;
            waddr   = to_q;
            wdata   = set_data;
            turn_d  = ~turn_q;
            done_d  = 1'b1;
            state_d = StIdle;
            if (!avail_valid) mask_d = '0;
         end
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q    <= StInit;
         idx_q      <= '0;
         from_q     <= '0;
         to_q       <= '0;
         src_q      <= '0;
         dst_q      <= '0;
         turn_q     <= ColWhite;
         mask_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= ErrNone;
         rd_piece_q <= '0;
         rd_avail_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         from_q     <= from_d;
         to_q       <= to_d;
         src_q      <= src_d;
         dst_q      <= dst_d;
         turn_q     <= turn_d;
         mask_q     <= mask_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         rd_piece_q <= rd_data;
         rd_avail_q <= mask_q[rd_sq] & flash_q;
      end
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         flash_cnt_q <= '0;
         flash_q     <= 1'b0;
      end else if (flash_cnt_q == CntW'(FLASH_DIV - 1)) begin
         flash_cnt_q <= '0;
         flash_q     <= ~flash_q;
      end else begin
         flash_cnt_q <= flash_cnt_q + 1'b1;
      end
   end

   assign mv_ready   = (state_q == StIdle);
   assign rd_piece   = rd_piece_q;
   assign rd_avail   = rd_avail_q;
   assign flash      = flash_q;
   assign turn       = turn_q;
   assign done_pulse = done_q;
   assign err_pulse  = err_q;
   assign err_code   = err_code_q;

endmodule

// File: tb/tb_board_move_sequencer.sv
// Directed bench for board_move_sequencer: move outcomes and renderer reads go through
// expectation queues and are compared when the DUT reports them.
module tb_board_move_sequencer;

   logic        clock = 1'b0;
   logic        rst_n = 1'b0;
   logic        mv_valid = 1'b0;
   logic        mv_ready;
   logic [5:0]  mv_from = '0;
   logic [5:0]  mv_to = '0;
   logic        avail_valid = 1'b0;
   logic [63:0] avail_mask = '0;
   logic [5:0]  rd_sq = '0;
   logic [3:0]  rd_piece;
   logic        rd_avail;
   logic        flash;
   logic        turn;
   logic        done_pulse;
   logic        err_pulse;
   logic [1:0]  err_code;

   int tests = 0;
   int fails = 0;

   logic [2:0] mv_q [$];
   logic [3:0] rd_q [$];

   // Independent flash-phase model for FLASH_DIV = 4.
   logic [1:0] fcnt_m = '0;
   logic       flash_m = 1'b0;
   logic       flash_prev_m = 1'b0;

   board_move_sequencer #(.FLASH_DIV(4)) dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .mv_valid    (mv_valid),
      .mv_ready    (mv_ready),
      .mv_from     (mv_from),
      .mv_to       (mv_to),
      .avail_valid (avail_valid),
      .avail_mask  (avail_mask),
      .rd_sq       (rd_sq),
      .rd_piece    (rd_piece),
      .rd_avail    (rd_avail),
      .flash       (flash),
      .turn        (turn),
      .done_pulse  (done_pulse),
      .err_pulse   (err_pulse),
      .err_code    (err_code)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (!rst_n) begin
         fcnt_m       <= '0;
         flash_m      <= 1'b0;
         flash_prev_m <= 1'b0;
      end else begin
         flash_prev_m <= flash_m;
         fcnt_m       <= fcnt_m + 2'd1;
         if (fcnt_m == 2'd3) flash_m <= ~flash_m;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no finish, required finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic read_check(input string tag, input logic [5:0] sq, input logic [3:0] exp);
      logic [3:0] e;
      rd_sq = sq;
      rd_q.push_back(exp);
      tick();
      e = rd_q.pop_front();
      check(tag, rd_piece, e);
   endtask

   // code 0 means the move must be applied; otherwise it is the required reject reason.
   task automatic do_move(input logic [5:0] f, input logic [5:0] t, input logic [1:0] code,
                          input logic load_on_set, input logic [63:0] m);
      int         n;
      bit         seen;
      logic [2:0] obs, e;
      n = 0;
      while (!mv_ready && n < 100) begin
         tick();
         n++;
      end
      check("mv_ready_wait", mv_ready, 1'b1);
      if (!mv_ready) return;
      mv_valid = 1'b1;
      mv_from  = f;
      mv_to    = t;
      mv_q.push_back({1'b0, code});
      tick();
      mv_valid = 1'b0;
      seen = 0;
      n = 0;
      while (!seen && n < 8) begin
         if (load_on_set && n == 3) begin
            avail_valid = 1'b1;
            avail_mask  = m;
         end
         tick();
         n++;
         avail_valid = 1'b0;
         if (done_pulse || err_pulse) seen = 1;
      end
      obs = done_pulse ? 3'd0 : (err_pulse ? {1'b0, err_code} : 3'b111);
      e = mv_q.pop_front();
      check("move_result", obs, e);
      check("move_latency", n, (code == 2'd0) ? 4 : 2);
      if (code == 2'd0) check("ready_with_done", mv_ready, 1'b1);
   endtask

   initial begin
      logic [63:0] m36, m20;
      m36 = '0;
      m36[36] = 1'b1;
      m20 = '0;
      m20[20] = 1'b1;

      // Reset values and INIT length
      rst_n = 1'b0;
      tick();
      tick();
      check("rst_mv_ready", mv_ready, 1'b0);
      check("rst_rd_piece", rd_piece, 4'h0);
      check("rst_rd_avail", rd_avail, 1'b0);
      check("rst_flash", flash, 1'b0);
      check("rst_turn", turn, 1'b0);
      check("rst_done", done_pulse, 1'b0);
      check("rst_err", err_pulse, 1'b0);
      check("rst_err_code", err_code, 2'd0);
      rst_n = 1'b1;
      repeat (63) tick();
      check("init_not_ready", mv_ready, 1'b0);
      tick();
      check("init_ready", mv_ready, 1'b1);

      read_check("start_sq0", 6'd0, 4'b1100);
      read_check("start_sq1", 6'd1, 4'b1011);
      read_check("start_sq4", 6'd4, 4'b1110);
      read_check("start_sq52", 6'd52, 4'b0001);
      read_check("start_sq60", 6'd60, 4'b0110);
      read_check("start_sq27", 6'd27, 4'b0000);
      check("flash_model", flash, flash_m);

      // Rejects at turn 0
      do_move(6'd12, 6'd28, 2'd2, 1'b0, '0);
      do_move(6'd20, 6'd28, 2'd1, 1'b0, '0);
      do_move(6'd56, 6'd48, 2'd3, 1'b0, '0);
      do_move(6'd52, 6'd52, 2'd3, 1'b0, '0);
      check("turn_after_rejects", turn, 1'b0);
      read_check("rej_sq12", 6'd12, 4'b1001);
      read_check("rej_sq28", 6'd28, 4'b0000);

      // Applied moves, captures and promotions
      do_move(6'd52, 6'd36, 2'd0, 1'b0, '0);
      check("turn_after_e4", turn, 1'b1);
      check("err_code_held", err_code, 2'd3);
      read_check("e4_sq52", 6'd52, 4'b0000);
      read_check("e4_sq36", 6'd36, 4'b0001);
      do_move(6'd8, 6'd24, 2'd0, 1'b0, '0);
      do_move(6'd48, 6'd8, 2'd0, 1'b0, '0);
      do_move(6'd9, 6'd17, 2'd0, 1'b0, '0);
      do_move(6'd8, 6'd1, 2'd0, 1'b0, '0);
      read_check("promo_w_sq1", 6'd1, 4'b0101);
      read_check("promo_w_sq8", 6'd8, 4'b0000);
      do_move(6'd24, 6'd57, 2'd0, 1'b0, '0);
      read_check("promo_b_sq57", 6'd57, 4'b1101);
      check("turn_after_promos", turn, 1'b0);

      // Mask load and flash on square 36
      rd_sq = 6'd36;
      avail_valid = 1'b1;
      avail_mask  = m36;
      tick();
      avail_valid = 1'b0;
      tick();
      for (int i = 0; i < 12; i++) begin
         tick();
         check("flash_phase", flash, flash_m);
         check("avail36_flash", rd_avail, flash_prev_m);
      end

      // Applied move clears the mask
      do_move(6'd51, 6'd43, 2'd0, 1'b0, '0);
      tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         check("avail36_cleared", rd_avail, 1'b0);
      end

      // Load on the SET cycle wins over the clear
      rd_sq = 6'd20;
      do_move(6'd10, 6'd18, 2'd0, 1'b1, m20);
      tick();
      for (int i = 0; i < 8; i++) begin
         tick();
         check("avail20_kept", rd_avail, flash_prev_m);
      end

      // Reset while the move sits in CHECK
      check("ready_before_abort", mv_ready, 1'b1);
      mv_valid = 1'b1;
      mv_from  = 6'd50;
      mv_to    = 6'd42;
      tick();
      mv_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      check("abort_ready", mv_ready, 1'b0);
      check("abort_err_code", err_code, 2'd0);
      check("abort_done", done_pulse, 1'b0);
      check("abort_flash", flash, 1'b0);
      check("abort_rd_piece", rd_piece, 4'h0);
      rst_n = 1'b1;
      repeat (64) tick();
      check("reinit_ready", mv_ready, 1'b1);
      check("reinit_turn", turn, 1'b0);
      read_check("reinit_sq50", 6'd50, 4'b0001);
      read_check("reinit_sq42", 6'd42, 4'b0000);
      read_check("reinit_sq52", 6'd52, 4'b0001);
      read_check("reinit_sq36", 6'd36, 4'b0000);
      read_check("reinit_sq1", 6'd1, 4'b1011);
      read_check("reinit_sq57", 6'd57, 4'b0011);
      read_check("reinit_sq8", 6'd8, 4'b1001);
      for (int i = 0; i < 8; i++) begin
         tick();
         check("reinit_mask_clear", rd_avail, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
